// File: rtl/fpga_mem_pkg.sv
// Shared types and line-geometry constants for the FPGA memory responder.
// Imported by the RAM and the responder top.
package fpga_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WACK,
    RWAIT,
    RDATA
  } state_t;

  localparam int LINE_BYTES = 32;
  localparam int BEATS      = 8;
  localparam int WORD_BITS  = 32;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LINE_LSB   = $clog2(LINE_BYTES);

endpackage

// File: rtl/fpga_mem_ram.sv
// Single-port word RAM, 1-cycle registered read, write-enabled port.
// Written to infer a block RAM; contents are never reset.
module fpga_mem_ram
  import fpga_mem_pkg::*;
#(
  parameter int WORDS = 65536,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] q
);

  logic [WORD_BITS-1:0] mem [WORDS];

  // write port plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side end of the controller link: line writes with ack, line reads.
// Optional macro FPGA_MEM_RESP_ERR_CHECK_EN enables the sticky protocol_err flag.
module fpga_mem_responder
  import fpga_mem_pkg::*;
#(
  parameter int MEM_WORDS    = 65536,
  parameter int BEATS        = 8,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_data_bus_c_to_m,
  input  logic        address_on_c_to_m,
  input  logic        data_on_c_to_m,
  input  logic        read_en_c_to_m,
  input  logic        write_en_c_to_m,
  output logic [31:0] address_data_bus_m_to_c,
  output logic        resp_m_to_c,
  output logic        protocol_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam int LW = 32 - LINE_LSB;

  state_t         state;
  logic [LW-1:0]  line;
  logic [BW-1:0]  beat;
  logic [CW-1:0]  cnt;
  logic           resp_q;
  logic           ack_q;

  logic           cmd_wr;
  logic           cmd_rd;
  logic           we;
  logic           last_beat;
  logic [BW-1:0]  rd_beat;
  logic [AW-1:0]  ram_addr;
  logic [31:0]    ram_q;

  assign cmd_wr = address_on_c_to_m && write_en_c_to_m
                  && !read_en_c_to_m;
  assign cmd_rd = address_on_c_to_m && read_en_c_to_m
                  && !write_en_c_to_m;

  assign we        = (state == WDATA) && data_on_c_to_m;
  assign last_beat = (beat == BW'(BEATS - 1));

  // RWAIT fetches word 0; each RDATA cycle prefetches the next word
  assign rd_beat  = (state == RDATA) ? beat + BW'(1) : '0;
  assign ram_addr = AW'({line, (we ? beat : rd_beat)});

  fpga_mem_ram #(
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (ram_addr),
    .wdata (address_data_bus_c_to_m),
    .q     (ram_q)
  );

  assign resp_m_to_c = resp_q;
  assign address_data_bus_m_to_c =
    !resp_q ? '0 :
    ack_q   ? {line, {LINE_LSB{1'b0}}} :
              ram_q;

  // transaction FSM with registered response strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      line   <= '0;
      beat   <= '0;
      cnt    <= '0;
      resp_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_wr) begin
            line  <= address_data_bus_c_to_m[31:LINE_LSB];
            beat  <= '0;
            state <= WDATA;
          end else if (cmd_rd) begin
            line  <= address_data_bus_c_to_m[31:LINE_LSB];
            beat  <= '0;
            cnt   <= CW'(READ_LATENCY - 2);
            state <= RWAIT;
          end
        end
        WDATA: begin
          if (data_on_c_to_m) begin
            beat <= beat + BW'(1);
            if (last_beat) begin
              resp_q <= 1'b1;
              ack_q  <= 1'b1;
              state  <= WACK;
            end
          end
        end
        WACK: begin
          state <= IDLE;
        end
        RWAIT: begin
          if (cnt == '0) begin
            beat   <= '0;
            resp_q <= 1'b1;
            state  <= RDATA;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RDATA: begin
          if (last_beat) begin
            state <= IDLE;
          end else begin
            beat   <= beat + BW'(1);
            resp_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPGA_MEM_RESP_ERR_CHECK_EN
  logic err_hit;
  logic err_q;

  // any beat the current state cannot accept
  always_comb begin
    err_hit = 1'b0;
    case (state)
      IDLE:
        err_hit = data_on_c_to_m
                  || (address_on_c_to_m && !(cmd_wr || cmd_rd));
      WDATA:
        err_hit = address_on_c_to_m;
      RWAIT, RDATA:
        err_hit = address_on_c_to_m || data_on_c_to_m;
      default:
        err_hit = 1'b0;
    endcase
  end

  // sticky until reset
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Directed scoreboard bench for fpga_mem_responder (MEM_WORDS=256).
// Expected responses carry the cycle they must appear in.
module tb_fpga_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        aon, don, rd, wr;
  logic [31:0] dout;
  logic        resp, perr;

  fpga_mem_responder #(
    .MEM_WORDS    (256),
    .BEATS        (8),
    .READ_LATENCY (4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .address_data_bus_c_to_m (din),
    .address_on_c_to_m       (aon),
    .data_on_c_to_m          (don),
    .read_en_c_to_m          (rd),
    .write_en_c_to_m         (wr),
    .address_data_bus_m_to_c (dout),
    .resp_m_to_c             (resp),
    .protocol_err            (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [256];
  logic        exp_err;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // compare every response beat against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (resp === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_resp", {31'b0, resp}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_data", dout, e.data);
      end
    end else begin
      chk("idle_bus", dout, 32'h0);
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        chk("missing_resp", {31'b0, resp}, 32'h1);
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    aon = 0; don = 0; rd = 0; wr = 0; din = '0;
  endtask

  function automatic int widx(logic [31:0] a, int b);
    return int'(a[7:5]) * 8 + b;
  endfunction

  task automatic do_reset();
    idle_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic write_line(logic [31:0] a, logic [31:0] base,
                            bit gapped, int nbeats, bit ack);
    idle_in();
    aon = 1; wr = 1; din = a;
    step();
    idle_in();
    for (int i = 0; i < nbeats; i++) begin
      if (gapped) repeat (i % 4) step();
      don = 1;
      din = base + 32'(i);
      model[widx(a, i)] = base + 32'(i);
      if (ack && i == 7)
        q.push_back('{cyc + 1, a & ~32'h1f});
      step();
      idle_in();
    end
  endtask

  task automatic read_cmd(logic [31:0] a);
    idle_in();
    aon = 1; rd = 1; din = a;
    for (int i = 0; i < 8; i++)
      q.push_back('{cyc + 4 + i, model[widx(a, i)]});
    step();
    idle_in();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'h0);
      q.delete();
    end
    step();
  endtask

  initial begin
`ifdef FPGA_MEM_RESP_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    idle_in();
    rst = 1;
    repeat (3) step();
    chk("rst_resp", {31'b0, resp}, 32'h0);
    chk("rst_bus", dout, 32'h0);
    chk("rst_err", {31'b0, perr}, 32'h0);
    rst = 0;
    step();

    // write then read
    write_line(32'h0000_1000, 32'hA0, 0, 8, 1);
    drain();
    read_cmd(32'h0000_1000);
    drain();

    // gapped write
    write_line(32'h0000_0020, 32'hB0, 1, 8, 1);
    drain();
    read_cmd(32'h0000_0020);
    drain();

    // alignment and address wrap
    read_cmd(32'h0000_101F);
    drain();
    read_cmd(32'h0000_0400);
    drain();
    write_line(32'h0000_0400, 32'hC0, 0, 8, 1);
    drain();
    read_cmd(32'h0000_1000);
    drain();

    // both enables set: ignored
    idle_in();
    aon = 1; rd = 1; wr = 1; din = 32'h0000_0020;
    step();
    idle_in();
    repeat (10) step();
    chk("err_both", {31'b0, perr}, {31'b0, exp_err});

    // data_on in IDLE
    do_reset();
    step();
    chk("err_cleared", {31'b0, perr}, 32'h0);
    don = 1; din = 32'hDEAD_BEEF;
    step();
    idle_in();
    step();
    chk("err_data_idle", {31'b0, perr}, {31'b0, exp_err});

    // address_on during RDATA does not disturb the burst
    do_reset();
    step();
    read_cmd(32'h0000_0020);
    repeat (5) step();
    aon = 1; wr = 1; din = 32'h0000_0060;
    step();
    idle_in();
    drain();
    chk("err_addr_rdata", {31'b0, perr}, {31'b0, exp_err});
    read_cmd(32'h0000_0060);
    drain();

    // reset mid-write after 3 beats
    do_reset();
    step();
    write_line(32'h0000_0060, 32'hD0, 0, 8, 1);
    drain();
    write_line(32'h0000_0060, 32'hE0, 0, 3, 0);
    do_reset();
    repeat (12) step();
    read_cmd(32'h0000_0060);
    drain();

    // back-to-back reads
    read_cmd(32'h0000_1000);
    repeat (11) step();
    read_cmd(32'h0000_0020);
    drain();

    // second read during RWAIT is ignored
    do_reset();
    step();
    read_cmd(32'h0000_0060);
    aon = 1; rd = 1; din = 32'h0000_0020;
    step();
    idle_in();
    drain();
    chk("err_rwait", {31'b0, perr}, {31'b0, exp_err});

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
